// File: rtl/modexp_scheduler_if.sv
// rtl/modexp_scheduler_if.sv - Montgomery multiplier operand/result bus between scheduler and MM core
interface modexp_scheduler_if #(
    parameter int WIDTH = 256
);
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_n;
    logic             mm_beg;
    logic [WIDTH-1:0] mm_out;
    logic             mm_ready_n;

    modport master (
        output mm_a, mm_b, mm_n, mm_beg,
        input  mm_out, mm_ready_n
    );

    modport slave (
        input  mm_a, mm_b, mm_n, mm_beg,
        output mm_out, mm_ready_n
    );
endinterface

// File: rtl/modexp_scheduler.sv
// rtl/modexp_scheduler.sv - LSB-first square-and-multiply sequencer for one shared Montgomery multiplier (option: MODEXP_EARLY_EXIT_EN)
module modexp_scheduler #(
    parameter int WIDTH    = 256,
    parameter int EXP_BITS = 256,
    parameter int CNT_W    = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] i_n,
    input  logic [WIDTH-1:0] i_e,
    input  logic [WIDTH-1:0] i_m_mont,
    input  logic [WIDTH-1:0] i_one_mont,
    output logic [WIDTH-1:0] o_result,
    output logic             o_done,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_op_cnt,
    modexp_scheduler_if.master mm
);
    typedef enum logic [3:0] {
        S_IDLE, S_BIT, S_MUL_L, S_MUL_W, S_SQR_L, S_SQR_W, S_FIN_L, S_FIN_W, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(EXP_BITS - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_t;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_op_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_done;

    logic             w_start_ok;
    logic             w_cap_r;
    logic             w_cap_t;
    logic             w_cap_fin;
    logic             w_idx_inc;
    logic             w_busy;
    logic             w_beg;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_rem;

    // Exponent bits still to be processed, current bit in position 0
    assign w_rem = r_e >> r_idx;

`ifdef MODEXP_EARLY_EXIT_EN
    logic [WIDTH-1:0] w_rem_next;
    // Exponent bits left once the current bit's multiply has been done
    assign w_rem_next = r_e >> (r_idx + 1'b1);
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, MM operand selection and datapath strobes
    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_cap_r    = 1'b0;
        w_cap_t    = 1'b0;
        w_cap_fin  = 1'b0;
        w_idx_inc  = 1'b0;
        w_busy     = 1'b1;
        w_beg      = 1'b0;
        w_a        = r_r;
        w_b        = r_t;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_start_ok = 1'b1;
                    w_next     = S_BIT;
                end
            end
            S_BIT: begin
                if (w_rem[0]) w_next = S_MUL_L;
                else          w_next = S_SQR_L;
`ifdef MODEXP_EARLY_EXIT_EN
                if (w_rem == '0) w_next = S_FIN_L;
`endif
            end
            S_MUL_L: begin
                w_next = S_MUL_W;
            end
            S_MUL_W: begin
                w_beg = 1'b1;
                if (!mm.mm_ready_n) begin
                    w_cap_r = 1'b1;
                    w_next  = S_SQR_L;
`ifdef MODEXP_EARLY_EXIT_EN
                    if (w_rem_next == '0) w_next = S_FIN_L;
`endif
                end
            end
            S_SQR_L: begin
                w_a    = r_t;
                w_next = S_SQR_W;
            end
            S_SQR_W: begin
                w_a   = r_t;
                w_beg = 1'b1;
                if (!mm.mm_ready_n) begin
                    w_cap_t = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_next = S_FIN_L;
                    end else begin
                        w_idx_inc = 1'b1;
                        w_next    = S_BIT;
                    end
                end
            end
            S_FIN_L: begin
                w_b    = ONE;
                w_next = S_FIN_W;
            end
            S_FIN_W: begin
                w_b   = ONE;
                w_beg = 1'b1;
                if (!mm.mm_ready_n) begin
                    w_cap_fin = 1'b1;
                    w_next    = S_DONE;
                end
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Job registers: latch on start, capture MM results, count operations
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n      <= '0;
            r_e      <= '0;
            r_r      <= '0;
            r_t      <= '0;
            r_idx    <= '0;
            r_op_cnt <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_n      <= i_n;
                r_e      <= i_e;
                r_t      <= i_m_mont;
                r_r      <= i_one_mont;
                r_idx    <= '0;
                r_op_cnt <= '0;
                r_result <= '0;
                r_done   <= 1'b0;
            end
            if (w_cap_r || w_cap_fin) r_r <= mm.mm_out;
            if (w_cap_t)              r_t <= mm.mm_out;
            if (w_cap_r || w_cap_t || w_cap_fin) r_op_cnt <= r_op_cnt + 1'b1;
            if (w_idx_inc)            r_idx <= r_idx + 1'b1;
            if (w_cap_fin) begin
                r_result <= mm.mm_out;
                r_done   <= 1'b1;
            end
        end
    end

    assign mm.mm_a   = w_a;
    assign mm.mm_b   = w_b;
    assign mm.mm_n   = r_n;
    assign mm.mm_beg = w_beg;
    assign o_result  = r_result;
    assign o_done    = r_done;
    assign o_busy    = w_busy;
    assign o_op_cnt  = r_op_cnt;
endmodule

// File: tb/tb_modexp_scheduler.sv
// tb/tb_modexp_scheduler.sv - Table-driven bench for modexp_scheduler with a behavioural mod-13 Montgomery multiplier
module tb_modexp_scheduler;
    localparam int WIDTH = 256;
    localparam int CNT_W = 9;
    localparam int LAT   = 2;
    localparam int LIMIT = 5000;
    localparam logic [WIDTH-1:0] N_MOD    = 256'd13;
    localparam logic [WIDTH-1:0] ONE_MONT = 256'd3;
    localparam longint RINV = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] i_n = '0;
    logic [WIDTH-1:0] i_e = '0;
    logic [WIDTH-1:0] i_m_mont = '0;
    logic [WIDTH-1:0] i_one_mont = '0;
    logic [WIDTH-1:0] o_result;
    logic             o_done;
    logic             o_busy;
    logic [CNT_W-1:0] o_op_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int viol     = 0;

    modexp_scheduler_if #(.WIDTH(WIDTH)) bus ();

    modexp_scheduler #(.WIDTH(WIDTH), .EXP_BITS(256), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .i_n(i_n), .i_e(i_e), .i_m_mont(i_m_mont), .i_one_mont(i_one_mont),
        .o_result(o_result), .o_done(o_done), .o_busy(o_busy), .o_op_cnt(o_op_cnt),
        .mm(bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] mm_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint la, lb;
        la = longint'(a[31:0]) % 13;
        lb = longint'(b[31:0]) % 13;
        return WIDTH'((la * lb * RINV) % 13);
    endfunction

    logic [WIDTH-1:0] m_la, m_lb, m_out;
    logic             m_rdy_n;
    logic             m_after;
    int               m_cnt;

    assign bus.mm_out     = m_out;
    assign bus.mm_ready_n = m_rdy_n;

    // Multiplier model: loads while mm_beg=0, answers LAT cycles later, flags protocol violations
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rdy_n <= 1'b1;
            m_after <= 1'b0;
            m_cnt   <= 0;
            m_out   <= '0;
            m_la    <= '0;
            m_lb    <= '0;
        end else if (!bus.mm_beg) begin
            m_la    <= bus.mm_a;
            m_lb    <= bus.mm_b;
            m_cnt   <= 0;
            m_rdy_n <= 1'b1;
            m_after <= 1'b0;
        end else begin
            if (bus.mm_a !== m_la || bus.mm_b !== m_lb || bus.mm_n !== N_MOD) viol <= viol + 1;
            if (m_after) begin
                viol <= viol + 1;
            end else if (!m_rdy_n) begin
                m_rdy_n <= 1'b1;
                m_after <= 1'b1;
            end else if (m_cnt == LAT) begin
                m_rdy_n <= 1'b0;
                m_out   <= mm_model(m_la, m_lb);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    typedef struct {
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] m_mont;
        logic [WIDTH-1:0] exp_res;
        int               ops_full;
        int               ops_early;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pick_ops(input int full, input int early);
`ifdef MODEXP_EARLY_EXIT_EN
        return early;
`else
        return full;
`endif
    endfunction

    task automatic pulse_start(input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] mm);
        i_n        = N_MOD;
        i_one_mont = ONE_MONT;
        i_e        = e;
        i_m_mont   = mm;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < LIMIT * 4; k++) begin
            if (o_done) break;
            @(negedge clk);
        end
        chk({name, "_done"}, {255'd0, o_done}, 256'd1);
    endtask

    task automatic run_job(input string name, input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] mm,
                           input logic [WIDTH-1:0] exp_res, input int exp_ops);
        int v0;
        v0 = viol;
        pulse_start(e, mm);
        wait_done(name);
        chk({name, "_result"}, o_result, exp_res);
        chk({name, "_op_cnt"}, WIDTH'(o_op_cnt), WIDTH'(exp_ops));
        chk({name, "_busy"}, {255'd0, o_busy}, 256'd0);
        chk({name, "_protocol"}, WIDTH'(viol - v0), 256'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] top_bit;
        top_bit = '0;
        top_bit[255] = 1'b1;
        vecs[0] = '{256'd5, 256'd6, 256'd6, 259, 5};
        vecs[1] = '{256'd0, 256'd6, 256'd1, 257, 1};
        vecs[2] = '{256'd1, 256'd6, 256'd2, 258, 2};
        vecs[3] = '{256'd2, 256'd6, 256'd4, 258, 3};
        vecs[4] = '{256'd3, 256'd9, 256'd1, 259, 4};
        vecs[5] = '{top_bit, 256'd6, 256'd9, 258, 257};

        repeat (3) @(negedge clk);
        chk("rst_busy", {255'd0, o_busy}, 256'd0);
        chk("rst_done", {255'd0, o_done}, 256'd0);
        chk("rst_result", o_result, 256'd0);
        chk("rst_op_cnt", WIDTH'(o_op_cnt), 256'd0);
        chk("rst_mm_beg", {255'd0, bus.mm_beg}, 256'd0);
        chk("rst_mm_a", bus.mm_a, 256'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_job($sformatf("vec%0d", i), vecs[i].e, vecs[i].m_mont, vecs[i].exp_res,
                    pick_ops(vecs[i].ops_full, vecs[i].ops_early));
        end

        // Abort during the first square of an E=5 job
        begin
            int k;
            pulse_start(256'd5, 256'd6);
            for (k = 0; k < LIMIT; k++) begin
                if (o_op_cnt == 9'd1 && bus.mm_beg) break;
                @(negedge clk);
            end
            chk("abort_reach_sqr_w", WIDTH'(o_op_cnt == 9'd1 && bus.mm_beg), 256'd1);
            reset = 1'b1;
            #1;
            chk("abort_busy_async", {255'd0, o_busy}, 256'd0);
            @(posedge clk);
            #1;
            chk("abort_busy", {255'd0, o_busy}, 256'd0);
            chk("abort_done", {255'd0, o_done}, 256'd0);
            chk("abort_mm_beg", {255'd0, bus.mm_beg}, 256'd0);
            chk("abort_op_cnt", WIDTH'(o_op_cnt), 256'd0);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            run_job("after_abort", 256'd5, 256'd6, 256'd6, pick_ops(259, 5));
        end

        // A start pulse while busy must not restart or alter the job
        begin
            int v0;
            v0 = viol;
            pulse_start(256'd5, 256'd6);
            repeat (20) @(negedge clk);
            chk("busy_before_restart", {255'd0, o_busy}, 256'd1);
            pulse_start(256'd0, 256'd9);
            wait_done("busy_start");
            chk("busy_start_result", o_result, 256'd6);
            chk("busy_start_op_cnt", WIDTH'(o_op_cnt), WIDTH'(pick_ops(259, 5)));
            chk("busy_start_protocol", WIDTH'(viol - v0), 256'd0);
            repeat (3) @(negedge clk);
            chk("done_hold_result", o_result, 256'd6);
            chk("done_hold_done", {255'd0, o_done}, 256'd1);
        end

        // Start from DONE clears the previous result immediately
        pulse_start(256'd1, 256'd6);
        chk("restart_clears_result", o_result, 256'd0);
        chk("restart_clears_done", {255'd0, o_done}, 256'd0);
        wait_done("restart");
        chk("restart_result", o_result, 256'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
